// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter, receiver and arbiter
package uart_pkg;
  localparam int WordSizeDefault = 8;
  typedef enum logic {ST_IDLE, ST_GRANTED} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin one-hot winner, scanning upward from the port after the last winner
module rr_picker #(
  parameter int NumPorts = 4
) (
  input  logic [NumPorts-1:0]         req_i,
  input  logic [$clog2(NumPorts)-1:0] last_i,
  output logic [NumPorts-1:0]         gnt_o,
  output logic                        any_o
);
  localparam int IdxW = $clog2(NumPorts);
  logic [NumPorts-1:0] rot;
  logic [NumPorts-1:0] pe;
  // Rotate requests so the port after the last winner sits at bit 0
  always_comb begin
    rot = '0;
    for (int i = 0; i < NumPorts; i++) rot[i] = req_i[IdxW'((i + int'(last_i) + 1) % NumPorts)];
  end
  assign pe = rot & (~rot + NumPorts'(1));
  // Rotate the isolated lowest request back to its real port position
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumPorts; i++) gnt_o[IdxW'((i + int'(last_i) + 1) % NumPorts)] = pe[i];
  end
  assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin sharing of one UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int WordSize = WordSizeDefault,
  parameter int MaxBurst = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPorts*WordSize-1:0] req_data_i,
  input  logic [NumPorts-1:0]          req_valid_i,
  input  logic [NumPorts-1:0]          req_last_i,
  output logic [NumPorts-1:0]          req_ack_o,
  output logic [WordSize-1:0]          tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ack_i,
  output logic [NumPorts-1:0]          grant_o,
  output logic                         busy_o
);
  localparam int IdxW = $clog2(NumPorts);
  localparam int CntW = $clog2(MaxBurst + 1);
  if (NumPorts < 2) begin : g_np_chk
    $error("uart_tx_arbiter: NumPorts must be >= 2");
  end
  if (MaxBurst < 1) begin : g_mb_chk
    $error("uart_tx_arbiter: MaxBurst must be >= 1");
  end
  arb_state_t          state_q, state_d;
  logic [NumPorts-1:0] grant_q, grant_d, pick;
  logic [IdxW-1:0]     last_q, last_d, own_idx;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WordSize-1:0] own_data;
  logic                own_valid, own_last, any_req, active, ack, rel;
  rr_picker #(.NumPorts(NumPorts)) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (pick),
    .any_o  (any_req)
  );
  // Select the owner's word, valid, last flag and index from the one-hot grant
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_idx   = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (grant_q[k]) begin
        own_data  = req_data_i[k*WordSize +: WordSize];
        own_valid = req_valid_i[k];
        own_last  = req_last_i[k];
        own_idx   = IdxW'(k);
      end
    end
  end
  // Reset drops the grant in the same cycle so no word is acked while it is asserted
  assign active     = (state_q == ST_GRANTED) && !rst_i;
  assign tx_valid_o = active && own_valid;
  assign tx_data_o  = active ? own_data : '0;
  assign ack        = tx_valid_o && tx_ack_i;
  assign req_ack_o  = ack ? grant_q : '0;
  assign grant_o    = active ? grant_q : '0;
  assign busy_o     = active;
  assign rel        = ack && (own_last || cnt_q == CntW'(MaxBurst - 1));
  // Arbitrate when idle; when granted count acked words and release on last or burst limit
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = (ack && cnt_q != CntW'(MaxBurst)) ? cnt_q + CntW'(1) : cnt_q;
    if (state_q == ST_IDLE) begin
      state_d = any_req ? ST_GRANTED : ST_IDLE;
      grant_d = pick;
      cnt_d   = '0;
    end else if (rel) begin
      state_d = ST_IDLE;
      grant_d = '0;
      last_d  = own_idx;
    end
  end
  // State register; port 0 has first priority after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IdxW'(NumPorts - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner cases and randomized model check of the arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;
  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_valid, req_last, req_ack, grant;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ack, busy;
  int n_chk = 0;
  int n_fail = 0;
  uart_tx_arbiter #(.NumPorts(N), .WordSize(W), .MaxBurst(MB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ack_o   (req_ack),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ack_i    (tx_ack),
    .grant_o     (grant),
    .busy_o      (busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic         rst;
    logic [31:0]  data;
    logic [3:0]   valid;
    logic [3:0]   last;
    logic         ack;
    logic [3:0]   e_grant;
    logic [3:0]   e_ack;
    logic         e_valid;
    logic [7:0]   e_data;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic r, input logic [31:0] d, input logic [3:0] v, input logic [3:0] l,
                              input logic a, input logic [3:0] eg, input logic [3:0] ea, input logic ev,
                              input logic [7:0] ed);
    vec_t x;
    x.rst = r; x.data = d; x.valid = v; x.last = l; x.ack = a;
    x.e_grant = eg; x.e_ack = ea; x.e_valid = ev; x.e_data = ed;
    return x;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic [31:0] d, input logic [3:0] v, input logic [3:0] l, input logic a);
    rst = r; req_data = d; req_valid = v; req_last = l; tx_ack = a;
    #2;
  endtask
  task automatic do_reset();
    drive(1'b1, '0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int log_p[$];
    int log_d[$];
    int s1, first2, n2, owner, lastw, words, w;
    logic p2done, ta, ev;
    logic [3:0] rv, rl, eg;
    logic [7:0] rd[N];
    logic [7:0] ed;
    int seq[N];
    int waitw[N];
    rst = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ack = 1'b0;
    tick();
    tick();
    tbl.push_back(mk(1, 32'h0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(1, 32'h0041_0000, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 32'h0041_0000, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 32'h0041_0000, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 1, 8'h41));
    tbl.push_back(mk(0, 32'h0042_0000, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 1, 8'h42));
    tbl.push_back(mk(0, 32'h0043_0000, 4'b0100, 4'b0100, 1, 4'b0100, 4'b0100, 1, 8'h43));
    tbl.push_back(mk(0, 32'h0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(1, 32'h0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00));
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 1, 4'b0000, 4'b0000, 0, 8'h00));
      tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 1, 4'b0001, 4'b0001, 1, 8'h30));
      tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 1, 4'b0000, 4'b0000, 0, 8'h00));
      tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 1, 4'b1000, 4'b1000, 1, 8'h33));
    end
    tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 1, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 0, 4'b0001, 4'b0000, 1, 8'h30));
    tbl.push_back(mk(0, 32'h3300_0030, 4'b1001, 4'b1111, 1, 4'b0001, 4'b0001, 1, 8'h30));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].data, tbl[i].valid, tbl[i].last, tbl[i].ack);
      chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tbl[i].e_grant));
      chk($sformatf("vec%0d req_ack", i), 64'(req_ack), 64'(tbl[i].e_ack));
      chk($sformatf("vec%0d tx_valid", i), 64'(tx_valid), 64'(tbl[i].e_valid));
      chk($sformatf("vec%0d tx_data", i), 64'(tx_data), 64'(tbl[i].e_data));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].e_grant != 4'b0000));
      tick();
    end
    do_reset();
    s1 = 0;
    p2done = 1'b0;
    for (int c = 0; c < 300 && (s1 < 40 || !p2done); c++) begin
      drive(1'b0, {8'h00, 8'hE2, 8'(s1), 8'h00}, {1'b0, !p2done, s1 < 40, 1'b0}, 4'b0100, 1'b1);
      if (req_ack[1]) begin log_p.push_back(1); log_d.push_back(int'(tx_data)); s1++; end
      if (req_ack[2]) begin log_p.push_back(2); log_d.push_back(int'(tx_data)); p2done = 1'b1; end
      tick();
    end
    chk("burst_done", 64'(s1 == 40 && p2done), 64'd1);
    first2 = -1;
    n2 = 0;
    foreach (log_p[i]) begin
      if (log_p[i] == 2) begin n2++; if (first2 < 0) first2 = i; end
    end
    chk("burst_len_before_p2", 64'(first2), 64'(MB));
    chk("p2_word_count", 64'(n2), 64'd1);
    if (log_p.size() >= 18) begin
      chk("resume_port", 64'(log_p[17]), 64'd1);
      chk("resume_word", 64'(log_d[17]), 64'd16);
    end else chk("burst_log_size", 64'(log_p.size()), 64'd41);
    do_reset();
    drive(1'b0, 32'h0000_5511, 4'b0010, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 32'h0000_5511, 4'b0010, 4'b0000, 1'b1);
    chk("gap_first_ack", 64'(req_ack), 64'b0010);
    chk("gap_first_data", 64'(tx_data), 64'h55);
    tick();
    for (int c = 0; c < 50; c++) begin
      drive(1'b0, 32'h0000_0011, 4'b0001, 4'b0000, 1'b1);
      chk($sformatf("gap%0d grant", c), 64'(grant), 64'b0010);
      chk($sformatf("gap%0d tx_valid", c), 64'(tx_valid), 64'd0);
      chk($sformatf("gap%0d req_ack", c), 64'(req_ack), 64'd0);
      tick();
    end
    drive(1'b0, 32'h0000_5611, 4'b0011, 4'b0010, 1'b1);
    chk("gap_last_ack", 64'(req_ack), 64'b0010);
    chk("gap_last_data", 64'(tx_data), 64'h56);
    tick();
    drive(1'b0, 32'h0000_0011, 4'b0001, 4'b0000, 1'b1);
    chk("gap_bubble_grant", 64'(grant), 64'd0);
    tick();
    drive(1'b0, 32'h0000_0011, 4'b0001, 4'b0000, 1'b1);
    chk("gap_p0_ack", 64'(req_ack), 64'b0001);
    tick();
    do_reset();
    drive(1'b0, 32'hD000_0000, 4'b1000, 4'b0000, 1'b1);
    tick();
    drive(1'b0, 32'hD000_0000, 4'b1000, 4'b0000, 1'b1);
    chk("rst_owner_grant", 64'(grant), 64'b1000);
    chk("rst_owner_ack", 64'(req_ack), 64'b1000);
    tick();
    drive(1'b1, 32'hD100_0007, 4'b1001, 4'b0000, 1'b1);
    chk("rst_during_ack", 64'(req_ack), 64'd0);
    chk("rst_during_valid", 64'(tx_valid), 64'd0);
    tick();
    drive(1'b0, 32'hD100_0007, 4'b1001, 4'b0000, 1'b1);
    chk("rst_after_grant", 64'(grant), 64'd0);
    chk("rst_after_ack", 64'(req_ack), 64'd0);
    chk("rst_after_busy", 64'(busy), 64'd0);
    tick();
    drive(1'b0, 32'hD100_0007, 4'b1001, 4'b0000, 1'b1);
    chk("rst_p0_wins", 64'(grant), 64'b0001);
    tick();
    do_reset();
    owner = -1; lastw = N - 1; words = 0;
    rv = '0; rl = '0;
    for (int p = 0; p < N; p++) begin rd[p] = '0; seq[p] = 0; waitw[p] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!rv[p] && $urandom_range(2) == 0) begin
          rv[p] = 1'b1;
          rd[p] = {2'(p), 6'(seq[p])};
          seq[p]++;
          rl[p] = ($urandom_range(2) == 0);
        end
      end
      ta = 1'($urandom_range(1));
      drive(1'b0, {rd[3], rd[2], rd[1], rd[0]}, rv, rl, ta);
      ev = owner >= 0 && rv[owner];
      eg = owner >= 0 ? 4'(1 << owner) : 4'b0000;
      ed = owner >= 0 ? rd[owner] : 8'h00;
      chk("rnd_grant", 64'(grant), 64'(eg));
      chk("rnd_tx_valid", 64'(tx_valid), 64'(ev));
      chk("rnd_req_ack", 64'(req_ack), 64'((ev && ta) ? eg : 4'b0000));
      chk("rnd_busy", 64'(busy), 64'(owner >= 0));
      if (ev) chk("rnd_tx_data", 64'(tx_data), 64'(ed));
      if (owner < 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && rv[(lastw + 1 + k) % N]) w = (lastw + 1 + k) % N;
        end
        if (w >= 0) begin owner = w; words = 0; waitw[w] = 0; end
      end else if (ev && ta) begin
        words++;
        for (int q = 0; q < N; q++) begin
          if (q != owner && rv[q]) begin
            waitw[q]++;
            chk($sformatf("rnd_starve_p%0d", q), 64'(waitw[q] > (N - 1) * MB), 64'd0);
          end
        end
        rv[owner] = 1'b0;
        if (rl[owner] || words == MB) begin lastw = owner; owner = -1; end
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NumPorts independent byte producers, such as a debug console, telemetry and a boot logger.
- Arbitration is round-robin.
- A grant is message-atomic: it is held until the requester flags the last word, or until MaxBurst words have gone out, whichever comes first.
- Downstream it drives the transmitter's data/valid/ack interface. Upstream it presents one identical data/valid/last/ack interface per port.

Parameters:
NumPorts, 4, number of requesters; must be >= 2, otherwise elaboration $error.
WordSize, 8, word width; must equal the transmitter's WordSize.
MaxBurst, 16, maximum words per grant before forced rotation; must be >= 1, otherwise elaboration $error.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous reset, active-high.
req_data_i  in  NumPorts*WordSize  port p's word in bits [p*WordSize +: WordSize].
req_valid_i  in  NumPorts  port p has a word pending.
req_last_i  in  NumPorts  port p's current word ends its message.
req_ack_o  out  NumPorts  word on port p consumed this cycle.
tx_data_o  out  WordSize  word to the transmitter.
tx_valid_o  out  1  word to the transmitter is valid.
tx_ack_i  in  1  transmitter accepted tx_data_o this cycle (combinational from tx_valid_o is legal).
grant_o  out  NumPorts  one-hot current owner; all zero when idle.
busy_o  out  1  a grant is held.

Behaviour:
- Reset values:
  - state ST_IDLE; grant_o, req_ack_o, tx_valid_o and busy_o are 0; tx_data_o is 0.
  - Round-robin pointer last_q = NumPorts-1, so port 0 has top priority first.
  - Burst counter = 0.
- Reset mid-message: the grant is dropped immediately. A word already accepted by the transmitter is not recalled. No ack is issued during or after reset.
- States:
  - ST_IDLE: no owner.
    - If any req_valid_i bit is set, pick the first set bit scanning (last_q+1) mod NumPorts upward with wrap.
    - Register the winner into grant_q, clear the burst counter, go to ST_GRANTED.
    - Arbitration is always registered: 1 cycle from req_valid_i rising to tx_valid_o.
  - ST_GRANTED, owner g:
    - Combinational mux: tx_data_o = port g data; tx_valid_o = req_valid_i[g].
    - req_ack_o[g] = tx_valid_o && tx_ack_i. All other req_ack_o bits are 0.
    - Each ack increments the burst counter. Width is $clog2(MaxBurst+1); the counter never wraps.
    - Release condition: ack && (req_last_i[g] || burst counter == MaxBurst-1).
    - On release: last_q <= g, then ST_IDLE.
    - A valid gap from the owner does not release the grant. Requesters must complete messages.
- Release and a new request in the same cycle: the new request is arbitrated on the next cycle (one idle bubble). The transmitter spends >= 10 bit times per word, so throughput is unaffected.
- MaxBurst = 1 degenerates to word-level round-robin.
- Outputs: grant_o = grant_q in ST_GRANTED, else 0. busy_o = (state == ST_GRANTED).
- Invariants:
  - req_ack_o is at most one-hot and only ever set with grant_o at the same bit.
  - tx_valid_o is never 1 in ST_IDLE.
- Request contract: once req_valid_i[p] is asserted, req_data_i and req_last_i for port p are stable until acked.

Decomposition:
- uart_pkg, shared with the transmitter/receiver:
  - arb_state_t enum {ST_IDLE, ST_GRANTED}
  - default word width constant.
- Sub-module rr_picker (combinational, parameter NumPorts):
  - Inputs: req vector and last-winner index.
  - Outputs: one-hot winner plus any_req.
  - Implemented by rotate, priority-encode, rotate back.
- The arbiter instantiates one rr_picker. Verification instantiates arbiter + uart_tx together as well.

Test Plan:
1. Reset, then port 2 sends 3 words 0x41,0x42,0x43 with last on 0x43 -> grant_o=0b0100 one cycle after valid; the transmitter receives exactly 41,42,43; grant drops after the third ack.
2. Ports 0 and 3 both request from reset, 1-word messages, held continuously -> grant order 0,3,0,3; one idle cycle between grants.
3. Port 1 streams 40 words with no last, MaxBurst=16; port 2 has a 1-word message pending -> port 1 sends 16 words, port 2 sends 1, port 1 resumes with word 17.
4. Owner deasserts valid for 50 cycles mid-message while port 0 requests -> grant stays on the owner, tx_valid_o=0 during the gap, port 0 gets no ack.
5. Assert rst_i while port 3 owns the grant with 2 words left -> next cycle grant_o=0, req_ack_o=0; after reset port 0 wins if requesting.
6. Random valid/last/ack traffic for 10k cycles with scoreboard -> per-port word order preserved, no interleaving within a message, ack one-hot, no port starved beyond (NumPorts-1)*MaxBurst words.
